// File: rtl/barrett_final_sub_pkg.sv
// barrett_pkg: shared definitions for the Barrett final-correction stage.
//   state_t      : FSM state encoding (IDLE=0, SUB=1, DONE=2)
//   MAX_ITER_DEF : default subtraction budget per operand
package barrett_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Barrett quotient error bound of 2, plus one step of margin.
    localparam int unsigned MAX_ITER_DEF = 3;

endpackage

// File: rtl/barrett_final_sub_rca.sv
// RCA_signed: n-bit ripple-carry adder.
//   A, B   in  n : addends
//   C_in   in  1 : carry in
//   S      out n : sum A+B+C_in (mod 2^n)
//   C_out  out 1 : carry out of the top bit
module RCA_signed #(
    parameter int unsigned n = 4
) (
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    input  logic         C_in,
    output logic [n-1:0] S,
    output logic         C_out
);

    logic [n:0] w_c;

    always_comb begin
        S      = '0;
        w_c    = '0;
        w_c[0] = C_in;
        for (int unsigned i = 0; i < n; i++) begin
            S[i]     = A[i] ^ B[i] ^ w_c[i];
            w_c[i+1] = (A[i] & B[i]) | (A[i] & w_c[i]) | (B[i] & w_c[i]);
        end
        C_out = w_c[n];
    end

endmodule

// File: rtl/barrett_final_sub.sv
// barrett_final_sub: final correction of a Barrett residue. Subtracts the
// modulus once per cycle until the residue drops below it.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : operand handshake (x, m sampled on accept only)
//   x [n+1:0], m [n-1:0]: residue and modulus
//   out_valid/out_ready : result handshake; r/err held until accepted
//   r [n-1:0]           : x mod m
//   err                 : m==0, or residue not reduced within MAX_ITER steps
module barrett_final_sub
    import barrett_pkg::*;
#(
    parameter int unsigned n        = 4,
    parameter int unsigned MAX_ITER = MAX_ITER_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n+1:0] x,
    input  logic [n-1:0] m,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] r,
    output logic         err
);

    localparam int unsigned       IW       = $clog2(MAX_ITER + 1);
    localparam logic [IW-1:0]     ITER_LIM = IW'(MAX_ITER);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [n+1:0]    r_acc;
    logic [n-1:0]    r_mod;
    logic [IW-1:0]   r_iter;
    logic [n-1:0]    r_res;
    logic            r_err;

    logic [n+1:0]    w_mod_inv;
    logic [n+1:0]    w_diff;
    logic            w_ge;      // carry out of acc - mod: acc >= mod

    assign w_mod_inv = ~{2'b00, r_mod};

    RCA_signed #(.n(n + 2)) u_sub (
        .A     (r_acc),
        .B     (w_mod_inv),
        .C_in  (1'b1),
        .S     (w_diff),
        .C_out (w_ge)
    );

    assign r   = r_res;
    assign err = r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = (m == '0) ? ST_DONE : ST_SUB;
            end
            ST_SUB: begin
                if (!w_ge || r_iter == ITER_LIM) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_mod  <= '0;
            r_iter <= '0;
            r_res  <= '0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_acc  <= x;
                        r_mod  <= m;
                        r_iter <= '0;
                        r_res  <= '0;
                        r_err  <= (m == '0);
                    end
                end
                ST_SUB: begin
                    if (w_ge && r_iter < ITER_LIM) begin
                        r_acc  <= w_diff;
                        r_iter <= r_iter + IW'(1);
                    end else begin
                        // Still >= mod here means the budget ran out.
                        r_res <= r_acc[n-1:0];
                        r_err <= w_ge;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_barrett_final_sub.sv
module tb_barrett_final_sub;
    import barrett_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] x;
    logic [3:0] m;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] r;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    barrett_final_sub #(.n(4), .MAX_ITER(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .m         (m),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Presents one operand, returns cycles from the accept edge until out_valid.
    task automatic run_op(input logic [5:0] xv, input logic [3:0] mv, output int lat);
        chk("in_ready_before_op", 8'(in_ready), 8'd1);
        x        = xv;
        m        = mv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) chk("out_valid_timeout", 8'(out_valid), 8'd1);
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        int sweep_err;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        x         = '0;
        m         = '0;
        out_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_in_ready",  8'(in_ready),  8'd1);
        chk("rst_out_valid", 8'(out_valid), 8'd0);
        chk("rst_r",         8'(r),         8'd0);
        chk("rst_err",       8'(err),       8'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 13 mod 5: two subtractions
        run_op(6'd13, 4'd5, lat);
        chk("x13m5_lat", 8'(lat), 8'd3);
        chk("x13m5_r",   8'(r),   8'd3);
        chk("x13m5_err", 8'(err), 8'd0);
        finish_op();

        // Already reduced
        run_op(6'd4, 4'd5, lat);
        chk("x4m5_lat", 8'(lat), 8'd1);
        chk("x4m5_r",   8'(r),   8'd4);
        chk("x4m5_err", 8'(err), 8'd0);
        finish_op();

        run_op(6'd5, 4'd5, lat);
        chk("x5m5_lat", 8'(lat), 8'd2);
        chk("x5m5_r",   8'(r),   8'd0);
        chk("x5m5_err", 8'(err), 8'd0);
        finish_op();

        // Zero modulus: result must be visible by E0+1
        out_ready = 1'b0;
        run_op(6'd9, 4'd0, lat);
        if (lat == 0) begin
            @(posedge clk); #1;
        end
        chk("m0_out_valid", 8'(out_valid), 8'd1);
        chk("m0_err",       8'(err),       8'd1);
        chk("m0_r",         8'(r),         8'd0);
        finish_op();

        // Budget exhausted
        run_op(6'd63, 4'd1, lat);
        chk("x63m1_lat", 8'(lat), 8'd4);
        chk("x63m1_err", 8'(err), 8'd1);
        finish_op();

        // Back-pressure in DONE with input noise
        out_ready = 1'b0;
        run_op(6'd14, 4'd5, lat);
        chk("bp_lat", 8'(lat), 8'd3);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            x = 6'($urandom_range(0, 63));
            m = 4'($urandom_range(0, 15));
            @(posedge clk); #1;
            chk("bp_r",         8'(r),         8'd4);
            chk("bp_err",       8'(err),       8'd0);
            chk("bp_out_valid", 8'(out_valid), 8'd1);
            chk("bp_in_ready",  8'(in_ready),  8'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready",  8'(in_ready),  8'd1);
        chk("bp_release_out_valid", 8'(out_valid), 8'd0);

        // Reset while in SUB
        x = 6'd15; m = 4'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rsub_in_sub", 8'(dut.r_state), 8'(ST_SUB));
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rsub_state",     8'(dut.r_state), 8'(ST_IDLE));
        chk("rsub_out_valid", 8'(out_valid),   8'd0);
        chk("rsub_r",         8'(r),           8'd0);
        chk("rsub_err",       8'(err),         8'd0);
        chk("rsub_in_ready",  8'(in_ready),    8'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("rsub_no_stale", 8'(out_valid), 8'd0);
        end

        // Exhaustive sweep of m in 1..15, x < 3*m against x % m
        sweep_err = 0;
        out_ready = 1'b1;
        for (int mv = 1; mv <= 15; mv++) begin
            for (int xv = 0; xv < 3 * mv; xv++) begin
                int fb;
                fb = n_fail;
                run_op(6'(xv), 4'(mv), lat);
                chk("sweep_r",   8'(r),   8'(xv % mv));
                chk("sweep_err", 8'(err), 8'd0);
                chk("sweep_lat", 8'(lat), 8'(xv / mv + 1));
                if (n_fail != fb) sweep_err++;
                finish_op();
            end
        end
        if (sweep_err != 0) $display("sweep: %0d operands with errors", sweep_err);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
